// File: rtl/seg7_capture_pkg.sv
// Shared constants for the 7-segment readback monitor: active-low segment
// patterns (a..g, index 0 = segment a), decoded special values and FSM states.
package seg7_capture_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] VAL_BLANK = 4'hF;
    localparam logic [3:0] VAL_ERR   = 4'hE;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PUBLISH = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seg7_capture_decode.sv
// seg7_decode: combinational inverse of the display's segment encoder.
// Unknown patterns decode to VAL_ERR and raise illegal_o.
module seg7_decode
    import seg7_capture_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] val_o,
    output logic       illegal_o
);

    always_comb begin
        val_o     = VAL_ERR;
        illegal_o = 1'b0;
        case (seg_i)
            SEG_0:     val_o = 4'd0;
            SEG_1:     val_o = 4'd1;
            SEG_2:     val_o = 4'd2;
            SEG_3:     val_o = 4'd3;
            SEG_4:     val_o = 4'd4;
            SEG_5:     val_o = 4'd5;
            SEG_6:     val_o = 4'd6;
            SEG_7:     val_o = 4'd7;
            SEG_8:     val_o = 4'd8;
            SEG_9:     val_o = 4'd9;
            SEG_BLANK: val_o = VAL_BLANK;
            default: begin
                val_o     = VAL_ERR;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Readback monitor for the multiplexed active-low 7-segment bus: captures each
// stable digit and publishes complete frames. SEG7_CAP_TIMEOUT_EN adds a watchdog.
module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:6]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   digits_o,
    output logic                  frame_valid_o,
    output logic                  err_o,
    output logic                  timeout_o
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    seg_t                 seg_q, seg_d;
    logic [DIGITS-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIGITS-1:0]    captured_q, captured_d;
    logic [4*DIGITS-1:0]  shadow_q, shadow_d;
    logic                 frame_err_q, frame_err_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic                 err_q, err_d;
    cap_state_e           state_q, state_d;

    logic       changed;
    logic       settle;
    logic       multi_sel;
    logic       one_hot;
    logic       latch;
    logic       abort;
    logic       publish;
    logic [3:0] dec_val;
    logic       dec_illegal;

    seg7_decode u_decode (
        .seg_i     (seg_q),
        .val_o     (dec_val),
        .illegal_o (dec_illegal)
    );

    // Change detection compares the value being registered now against the
    // copy registered last edge, so a steady input latches STABLE_CYCLES edges in.
    always_comb begin
        seg_d     = seg_in;
        sel_d     = dig_sel;
        changed   = (seg_in != seg_q) || (dig_sel != sel_q);
        cnt_d     = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        settle    = !changed && (cnt_q == CNT_PRE);
        multi_sel = |(sel_q & (sel_q - 1'b1));
        one_hot   = (sel_q != '0) && !multi_sel;
        latch     = settle && one_hot && ((captured_q & sel_q) == '0);
        abort     = settle && multi_sel;
        publish   = (state_q == ST_COLLECT) && (&captured_q);
    end

    always_comb begin
        state_d     = state_q;
        captured_d  = captured_q;
        shadow_d    = shadow_q;
        frame_err_d = frame_err_q;
        digits_d    = digits_q;
        err_d       = err_q;

        case (state_q)
            ST_COLLECT: begin
                if (publish) begin
                    state_d     = ST_PUBLISH;
                    digits_d    = shadow_q;
                    err_d       = frame_err_q;
                    captured_d  = '0;
                    frame_err_d = 1'b0;
                end
            end
            ST_PUBLISH: state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase

        if (latch) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (sel_q[k]) begin
                    shadow_d[4*k +: 4] = dec_val;
                    captured_d[k]      = 1'b1;
                end
            end
            if (dec_illegal) frame_err_d = 1'b1;
        end

        // An overlapping select spoils the frame; shadow is left as-is.
        if (abort) begin
            captured_d  = '0;
            frame_err_d = 1'b0;
            err_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= SEG_BLANK;
            sel_q       <= '0;
            cnt_q       <= '0;
            captured_q  <= '0;
            shadow_q    <= '0;
            frame_err_q <= 1'b0;
            digits_q    <= '0;
            err_q       <= 1'b0;
            state_q     <= ST_COLLECT;
        end else begin
            seg_q       <= seg_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            shadow_q    <= shadow_d;
            frame_err_q <= frame_err_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

    assign digits_o      = digits_q;
    assign err_o         = err_q;
    assign frame_valid_o = (state_q == ST_PUBLISH);

`ifdef SEG7_CAP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // Cleared on the publishing edge so timeout_o drops as frame_valid_o rises.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (publish) begin
            wd_d      = '0;
            timeout_d = 1'b0;
        end else begin
            if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
            if (wd_d == WD_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
